// File: rtl/gpio_svc_pkg.sv
// gpio_svc_pkg
// Shared definitions for the GPIO edge servicer:
//   - svc_state_t   : servicer FSM state encoding
//   - GPIO_REG_*    : register addresses of the edge-capturing GPIO peripheral
package gpio_svc_pkg;

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_IDLE     = 3'd1,
      S_RD_ISSUE = 3'd2,
      S_RD_WAIT  = 3'd3,
      S_CLR      = 3'd4,
      S_PUSH     = 3'd5
   } svc_state_t;

   localparam logic [1:0] GPIO_REG_DATA = 2'd0;
   localparam logic [1:0] GPIO_REG_MASK = 2'd2;
   localparam logic [1:0] GPIO_REG_EDGE = 2'd3;

endpackage

// File: rtl/gpio_svc_tick.sv
// gpio_svc_tick
// Poll interval generator. Counts 0..POLL_CYCLES-1 and wraps; tick is high
// for the single cycle in which the count sits at its last value (the wrap).
// POLL_CYCLES = 0 disables polling: tick is tied low and no counter exists.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-high reset (count returns to 0)
//   tick  out  one-cycle poll request
module gpio_svc_tick #(
   parameter int unsigned POLL_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   generate
      if (POLL_CYCLES == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = clk ^ reset;
         assign tick          = 1'b0;
      end else begin : g_on
         localparam int unsigned CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
         localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_CYCLES - 1);

         logic [CNT_W-1:0] count;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               count <= '0;
            end else if (count == LAST) begin
               count <= '0;
            end else begin
               count <= count + 1'b1;
            end
         end

         assign tick = (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/gpio_edge_servicer.sv
// gpio_edge_servicer
// Avalon-MM initiator that services an edge-capturing GPIO input peripheral.
// After reset it writes MASK_INIT to the peripheral irq_mask register, then on
// each trigger (rising gpio_irq, poll tick, or a trigger remembered while busy)
// it reads edge_capture, clears exactly the bits it read, and posts any
// non-zero capture as an event on a valid/ready stream.
//
// Configuration macro: GPIO_EDGE_SVC_TIMESTAMP_EN
//   defined   : free-running TS_W-bit counter, sampled with each read
//   undefined : no counter, ev_stamp is constant 0
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   avm_address      peripheral register address
//   avm_chipselect   peripheral select
//   avm_write_n      active-low write strobe
//   avm_writedata    write data
//   avm_readdata     peripheral read data (registered, latency 1)
//   gpio_irq         peripheral interrupt level
//   ev_valid/ready   event handshake toward the consumer
//   ev_bits          captured edge bits
//   ev_stamp         timestamp of the read
module gpio_edge_servicer
   import gpio_svc_pkg::*;
#(
   parameter logic [31:0] MASK_INIT   = 32'hFFFF_FFFF,
   parameter int unsigned POLL_CYCLES = 0,
   parameter int unsigned TS_W        = 32
) (
   input  logic            clk,
   input  logic            reset,
   output logic [1:0]      avm_address,
   output logic            avm_chipselect,
   output logic            avm_write_n,
   output logic [31:0]     avm_writedata,
   input  logic [31:0]     avm_readdata,
   input  logic            gpio_irq,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [31:0]     ev_bits,
   output logic [TS_W-1:0] ev_stamp
);

   svc_state_t  state;
   svc_state_t  next_state;
   logic        irq_q;
   logic        pending;
   logic        poll_tick;
   logic        irq_rise;
   logic        trig_now;
   logic        trigger;
   logic [31:0] cap;

   gpio_svc_tick #(
      .POLL_CYCLES (POLL_CYCLES)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (poll_tick)
   );

   assign irq_rise = gpio_irq & ~irq_q;
   assign trig_now = irq_rise | poll_tick;
   assign trigger  = pending | trig_now;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_INIT;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_INIT:     next_state = S_IDLE;
         S_IDLE:     if (trigger) next_state = S_RD_ISSUE;
         S_RD_ISSUE: next_state = S_RD_WAIT;
         // Decision uses the same read data that is being captured into cap.
         S_RD_WAIT:  next_state = (avm_readdata == 32'h0) ? S_IDLE : S_CLR;
         S_CLR:      next_state = S_PUSH;
         S_PUSH:     if (ev_ready) next_state = S_IDLE;
         default:    next_state = S_INIT;
      endcase
   end

   // Output decode. Reset is folded in so the bus stays quiet while reset is
   // held, even though the FSM already sits in S_INIT; the mask write then
   // appears in the first cycle after release.
   always_comb begin
      avm_address    = 2'd0;
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_writedata  = 32'h0;
      ev_valid       = 1'b0;
      if (!reset) begin
         case (state)
            S_INIT: begin
               avm_address    = GPIO_REG_MASK;
               avm_chipselect = 1'b1;
               avm_write_n    = 1'b0;
               avm_writedata  = MASK_INIT;
            end
            S_RD_ISSUE, S_RD_WAIT: begin
               avm_address    = GPIO_REG_EDGE;
               avm_chipselect = 1'b1;
            end
            S_CLR: begin
               // Write-1-to-clear only the bits that were read; edges that
               // arrived after the read stay in the peripheral.
               avm_address    = GPIO_REG_EDGE;
               avm_chipselect = 1'b1;
               avm_write_n    = 1'b0;
               avm_writedata  = cap;
            end
            S_PUSH: begin
               ev_valid = 1'b1;
            end
            default: begin
               ev_valid = 1'b0;
            end
         endcase
      end
   end

   // Trigger tracking and capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q   <= 1'b0;
         pending <= 1'b0;
         cap     <= 32'h0;
      end else begin
         irq_q <= gpio_irq;
         // In IDLE any trigger is consumed by the move to RD_ISSUE, so the
         // flag only needs to remember triggers seen while busy.
         if (state == S_IDLE) begin
            pending <= 1'b0;
         end else if (trig_now) begin
            pending <= 1'b1;
         end
         if (state == S_RD_WAIT) begin
            cap <= avm_readdata;
         end
      end
   end

   assign ev_bits = cap;

`ifdef GPIO_EDGE_SVC_TIMESTAMP_EN
   logic [TS_W-1:0] ts_count;
   logic [TS_W-1:0] stamp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_count <= '0;
         stamp    <= '0;
      end else begin
         ts_count <= ts_count + 1'b1;
         if (state == S_RD_WAIT) begin
            stamp <= ts_count;
         end
      end
   end

   assign ev_stamp = stamp;
`else
   assign ev_stamp = '0;
`endif

endmodule

// File: doc/gpio_edge_servicer.md
# gpio_edge_servicer

Avalon-MM initiator that services an edge-capturing GPIO input peripheral without CPU involvement. It programs the peripheral's interrupt mask after reset, then reads and clears its edge-capture register whenever the peripheral's interrupt rises or a poll interval expires. Each non-zero capture is posted as an event on a valid/ready stream toward the ECU event logic. It sits between one GPIO input port's slave interface and the event consumer.

## Interface

Parameters:
- MASK_INIT, 32'hFFFF_FFFF, value written to the peripheral irq_mask register (address 2) after reset.
- POLL_CYCLES, 0, poll interval in clk cycles; 0 disables polling.
- TS_W, 32, event timestamp width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- avm_address  out  2  peripheral register address.
- avm_chipselect  out  1  peripheral select.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  peripheral read data, registered in the peripheral (fixed latency 1).
- gpio_irq  in  1  peripheral interrupt (level).
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts event.
- ev_bits  out  32  captured edge bits.
- ev_stamp  out  TS_W  timestamp of the read.

## Operation

- Register map used: 0 data, 2 irq_mask, 3 edge_capture (write-1-to-clear).
- FSM states: INIT, IDLE, RD_ISSUE, RD_WAIT, CLR, PUSH.
- INIT: one cycle. Drive address 2, chipselect 1, write_n 0, writedata MASK_INIT. Then go to IDLE.
- IDLE: go to RD_ISSUE when a trigger is present. Trigger = pending flag, or rising edge of gpio_irq (gpio_irq & ~irq_q), or poll tick.
- RD_ISSUE: drive address 3, chipselect 1, write_n 1.
- RD_WAIT: keep address 3. Capture avm_readdata into cap and the timestamp into stamp.
  - If cap==0: go to IDLE, no event.
  - Otherwise: go to CLR.
- CLR: one cycle. Drive address 3, write_n 0, writedata = cap, so only the bits read are cleared. Then go to PUSH.
- PUSH: ev_valid=1, ev_bits=cap, ev_stamp=stamp, all held stable until ev_ready. Go to IDLE in the cycle ev_valid & ev_ready.
- Triggers outside IDLE set the pending flag; entering RD_ISSUE clears it. Multiple triggers collapse into one service pass.
- Poll counter: counts 0..POLL_CYCLES-1 and wraps, producing a one-cycle tick on the wrap. It runs in every state.
- Outside the write states, avm_write_n=1. avm_chipselect is 0 in IDLE and PUSH.
- Known boundary: an edge on bit k arriving in the CLR cycle, or after the read but before the clear, is lost for bit k. The peripheral gives clear priority over set. The verification engineer checks this as intended behaviour.

## Timing

- Reset values:
  - state=INIT, pending=0, irq_q=0.
  - avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0.
  - ev_valid=0, ev_bits=0, ev_stamp=0, timestamp=0, poll count=0.
- Reset mid-operation aborts any access and any held event. The mask write repeats in the first cycle after reset deasserts.
- Latency: gpio_irq sampled high at edge E0 with irq_q=0 → RD_ISSUE cycle E0+1, RD_WAIT E0+2, CLR E0+3, ev_valid high from E0+4.
- cap is sampled at the end of RD_WAIT, i.e. one cycle after the address is presented.
- A sustained gpio_irq level does not retrigger; only its rising edge does.
- Back-to-back events: at minimum, a 5-cycle spacing when ev_ready is held high.

## Configuration

- GPIO_EDGE_SVC_TIMESTAMP_EN defined:
  - A free-running TS_W-bit counter increments every cycle and wraps modulo 2^TS_W.
  - It is sampled in RD_WAIT.
- Not defined: no counter exists and ev_stamp is constant 0.

## Structure

- Shared package gpio_svc_pkg holds:
  - the state enum;
  - register address constants GPIO_REG_DATA=2'd0, GPIO_REG_MASK=2'd2, GPIO_REG_EDGE=2'd3.
- One sub-module, gpio_svc_tick: the POLL_CYCLES counter and tick generator, tied off when POLL_CYCLES=0.

## Test plan

- Reset release → cycle 1 writes 32'hFFFF_FFFF to address 2; the bus is idle afterward.
- Model peripheral edge_capture=32'h0000_0005, irq rises → read at addr 3, write 32'h5 to addr 3, then ev_bits=32'h5 on ev_valid 4 cycles after irq sampled.
- ev_ready held low 10 cycles during PUSH, irq pulses again → event held stable; a second service pass starts right after the handshake (pending flag).
- POLL_CYCLES=8, irq tied low, capture=32'h8000_0000 → read every 8 cycles; one event; subsequent polls read 0 and produce no event.
- Reset asserted in CLR → no event emitted; the INIT mask write repeats after release.
- With GPIO_EDGE_SVC_TIMESTAMP_EN: two events 20 cycles apart → ev_stamp difference = 20. Without the macro: ev_stamp=0.
